// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array receive datapath.
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2
   } collector_state_e;

   // Width of a counter that must be able to hold the value n (0..n inclusive).
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/result_column_buffer.sv
// Storage for one result column: N-deep element buffer, write index and overflow detect.
module result_column_buffer
   import systolic_pkg::*;
#(
   parameter int unsigned MATRIX_SIZE = 2,
   parameter int unsigned DATA_SIZE   = 32,
   parameter int unsigned IDX_W       = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 wr_en,
   input  logic [DATA_SIZE-1:0] wr_data,
   input  logic [IDX_W-1:0]     rd_idx,
   output logic [DATA_SIZE-1:0] rd_data,
   output logic                 full_next,
   output logic                 ovf
);

   localparam int unsigned CntW = cnt_width(MATRIX_SIZE);

   logic [CntW-1:0]      wr_idx_q, wr_idx_d;
   logic [DATA_SIZE-1:0] mem_q [MATRIX_SIZE];
   logic [DATA_SIZE-1:0] mem_d [MATRIX_SIZE];
   logic                 full;

   assign full      = (wr_idx_q == CntW'(MATRIX_SIZE));
   // Full including a write landing this cycle, so the FSM can leave COLLECT without a bubble.
   assign full_next = full || (wr_en && (wr_idx_q == CntW'(MATRIX_SIZE - 1)));
   assign ovf       = wr_en && full;
   assign rd_data   = mem_q[rd_idx];

   // Next-state: clear the index on an accepted start, otherwise append the element if room.
   always_comb begin
      wr_idx_d = wr_idx_q;
      mem_d    = mem_q;
      if (clear) begin
         wr_idx_d = '0;
      end else if (wr_en && !full) begin
         mem_d[wr_idx_q[IDX_W-1:0]] = wr_data;
         wr_idx_d                   = wr_idx_q + 1'b1;
      end
   end

   // State registers; the buffer contents are only cleared by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_idx_q <= '0;
         mem_q    <= '{default: '0};
      end else begin
         wr_idx_q <= wr_idx_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/result_collector.sv
// Collects skewed per-column results, realigns them into rows and drains them over valid/ready.
module result_collector
   import systolic_pkg::*;
#(
   parameter int unsigned MATRIX_SIZE = 2,
   parameter int unsigned DATA_SIZE   = 32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [MATRIX_SIZE-1:0]           col_valid,
   input  logic [MATRIX_SIZE*DATA_SIZE-1:0] col_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [MATRIX_SIZE*DATA_SIZE-1:0] out_data,
   output logic                             busy,
   output logic                             done,
   output logic                             overflow_err
);

   localparam int unsigned IdxW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

   collector_state_e       state_q, state_d;
   logic [IdxW-1:0]        drain_row_q, drain_row_d;
   logic                   out_valid_q, out_valid_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   ovf_q, ovf_d;
   logic                   clear;
   logic [MATRIX_SIZE-1:0] wr_en;
   logic [MATRIX_SIZE-1:0] col_full_next;
   logic [MATRIX_SIZE-1:0] col_ovf;

   for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
      result_column_buffer #(
         .MATRIX_SIZE (MATRIX_SIZE),
         .DATA_SIZE   (DATA_SIZE),
         .IDX_W       (IdxW)
      ) u_col (
         .clk       (clk),
         .reset     (reset),
         .clear     (clear),
         .wr_en     (wr_en[j]),
         .wr_data   (col_data[j*DATA_SIZE +: DATA_SIZE]),
         .rd_idx    (drain_row_q),
         .rd_data   (out_data[j*DATA_SIZE +: DATA_SIZE]),
         .full_next (col_full_next[j]),
         .ovf       (col_ovf[j])
      );
   end

   // FSM next-state, column write enables and status register updates.
   always_comb begin
      state_d     = state_q;
      drain_row_d = drain_row_q;
      done_d      = done_q;
      ovf_d       = ovf_q;
      clear       = 1'b0;
      wr_en       = '0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = COLLECT;
               clear   = 1'b1;
               done_d  = 1'b0;
               ovf_d   = 1'b0;
            end
            // A result arriving with no collection armed is lost.
            if (|col_valid) ovf_d = 1'b1;
         end
         COLLECT: begin
            wr_en = col_valid;
            if (|col_ovf) ovf_d = 1'b1;
            if (&col_full_next) begin
               state_d     = DRAIN;
               drain_row_d = '0;
            end
         end
         DRAIN: begin
            if (|col_valid) ovf_d = 1'b1;
            // out_valid is always high in DRAIN, so out_ready alone marks a handshake.
            if (out_ready) begin
               if (drain_row_q == IdxW'(MATRIX_SIZE - 1)) begin
                  state_d     = IDLE;
                  done_d      = 1'b1;
                  drain_row_d = '0;
               end else begin
                  drain_row_d = drain_row_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d      = (state_d != IDLE);
      out_valid_d = (state_d == DRAIN);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         drain_row_q <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_row_q <= drain_row_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign overflow_err = ovf_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector with a row scoreboard checked on every handshake.
module tb_result_collector;

   localparam int unsigned N = 2;
   localparam int unsigned D = 32;
   localparam int unsigned W = N * D;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [N-1:0] col_valid;
   logic [W-1:0] col_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         busy;
   logic         done;
   logic         overflow_err;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   result_collector #(
      .MATRIX_SIZE (N),
      .DATA_SIZE   (D)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .col_valid    (col_valid),
      .col_data     (col_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .busy         (busy),
      .done         (done),
      .overflow_err (overflow_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [D-1:0] d1, input logic [D-1:0] d0);
      col_valid = v;
      col_data  = {d1, d0};
      step();
      col_valid = '0;
      col_data  = '0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      check(tag, W'(done), W'(1));
   endtask

   // Scoreboard: every accepted row must match the oldest expected row.
   always @(negedge clk) begin
      if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("row_unexpected", out_data, 'x);
         end else begin
            check("row", out_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      col_valid = '0;
      col_data  = '0;
      out_ready = 1'b1;
      step();
      step();
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_busy", W'(busy), W'(0));
      check("rst_done", W'(done), W'(0));
      check("rst_ovf", W'(overflow_err), W'(0));
      check("rst_out_data", out_data, '0);
      reset = 1'b0;
      step();

      // Aligned columns.
      pulse_start();
      check("aligned_busy", W'(busy), W'(1));
      exp_q.push_back({32'h11, 32'h10});
      exp_q.push_back({32'h21, 32'h20});
      drive(2'b11, 32'h11, 32'h10);
      check("aligned_collecting", W'(out_valid), W'(0));
      drive(2'b11, 32'h21, 32'h20);
      check("aligned_latency", W'(out_valid), W'(1));
      check("aligned_row0_data", out_data, {32'h21 - 32'h10, 32'h10});
      wait_done("aligned_done");
      check("aligned_busy_low", W'(busy), W'(0));
      check("aligned_valid_low", W'(out_valid), W'(0));
      check("aligned_drained", W'(exp_q.size()), W'(0));

      // Skewed columns.
      pulse_start();
      check("skew_done_dropped", W'(done), W'(0));
      exp_q.push_back({32'hA1, 32'hA0});
      exp_q.push_back({32'hB1, 32'hB0});
      drive(2'b01, 32'h0, 32'hA0);
      drive(2'b11, 32'hA1, 32'hB0);
      check("skew_not_yet", W'(out_valid), W'(0));
      drive(2'b10, 32'hB1, 32'h0);
      check("skew_latency", W'(out_valid), W'(1));
      wait_done("skew_done");

      // Backpressure.
      out_ready = 1'b0;
      pulse_start();
      exp_q.push_back({32'h31, 32'h30});
      exp_q.push_back({32'h41, 32'h40});
      drive(2'b11, 32'h31, 32'h30);
      drive(2'b11, 32'h41, 32'h40);
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_valid", W'(out_valid), W'(1));
         check("bp_hold_data", out_data, {32'h31, 32'h30});
         step();
      end
      check("bp_no_done", W'(done), W'(0));
      out_ready = 1'b1;
      step();
      check("bp_row1_presented", out_data, {32'h41, 32'h40});
      check("bp_done_after_row1", W'(done), W'(0));
      wait_done("bp_done");
      check("bp_drained", W'(exp_q.size()), W'(0));

      // Overflow on column 0 while column 1 is still filling.
      out_ready = 1'b0;
      pulse_start();
      exp_q.push_back({32'h51, 32'h50});
      exp_q.push_back({32'h61, 32'h60});
      drive(2'b01, 32'h0, 32'h50);
      drive(2'b01, 32'h0, 32'h60);
      check("ovf_clean", W'(overflow_err), W'(0));
      drive(2'b01, 32'h0, 32'hDEAD);
      check("ovf_set", W'(overflow_err), W'(1));
      drive(2'b10, 32'h51, 32'h0);
      drive(2'b10, 32'h61, 32'h0);
      check("ovf_sticky", W'(overflow_err), W'(1));
      out_ready = 1'b1;
      wait_done("ovf_done");
      check("ovf_still_set", W'(overflow_err), W'(1));

      // Reset in DRAIN with drain_row=1, then a fresh collection.
      out_ready = 1'b0;
      pulse_start();
      check("start_clears_ovf", W'(overflow_err), W'(0));
      exp_q.push_back({32'h71, 32'h70});
      exp_q.push_back({32'h81, 32'h80});
      drive(2'b11, 32'h71, 32'h70);
      drive(2'b11, 32'h81, 32'h80);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("rst_mid_row1", out_data, {32'h81, 32'h80});
      reset = 1'b1;
      #1;
      exp_q.delete();
      check("rst_mid_valid", W'(out_valid), W'(0));
      check("rst_mid_busy", W'(busy), W'(0));
      check("rst_mid_done", W'(done), W'(0));
      check("rst_mid_data", out_data, '0);
      step();
      reset     = 1'b0;
      out_ready = 1'b1;
      step();
      pulse_start();
      exp_q.push_back({32'h91, 32'h90});
      exp_q.push_back({32'h99, 32'h98});
      drive(2'b11, 32'h91, 32'h90);
      drive(2'b11, 32'h99, 32'h98);
      wait_done("rst_fresh_done");

      // Start ignored in COLLECT and DRAIN.
      out_ready = 1'b0;
      pulse_start();
      exp_q.push_back({32'hC1, 32'hC0});
      exp_q.push_back({32'hD1, 32'hD0});
      start = 1'b1;
      drive(2'b11, 32'hC1, 32'hC0);
      pulse_start();
      check("ign_collect_busy", W'(busy), W'(1));
      check("ign_collect_valid", W'(out_valid), W'(0));
      drive(2'b11, 32'hD1, 32'hD0);
      check("ign_drain_entered", W'(out_valid), W'(1));
      pulse_start();
      check("ign_drain_valid", W'(out_valid), W'(1));
      check("ign_drain_busy", W'(busy), W'(1));
      check("ign_drain_data", out_data, {32'hC1, 32'hC0});
      out_ready = 1'b1;
      wait_done("ign_done");
      check("ign_drained", W'(exp_q.size()), W'(0));
      check("ign_no_ovf", W'(overflow_err), W'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Receive end of the systolic array datapath: the scheduler launches loads and multiplies; this block collects the skewed per-column results from the bottom PE row.
- Reassembles the results into aligned matrix rows in a local register buffer.
- Hands the rows one at a time to a downstream consumer over a valid/ready handshake.
- Raises done once the full result matrix has been consumed.

Parameters:
- MATRIX_SIZE, 2, array dimension N; N rows and N columns of results.
- DATA_SIZE, 32, width of one result element in bits.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; arms a new collection. Honoured only in IDLE.
- col_valid  input  MATRIX_SIZE  bit j: col_data element j is valid this cycle.
- col_data  input  MATRIX_SIZE*DATA_SIZE  column j result at bits [j*DATA_SIZE +: DATA_SIZE].
- out_valid  output  1  out_data holds an aligned result row.
- out_ready  input  1  consumer accepts the row when out_valid && out_ready.
- out_data  output  MATRIX_SIZE*DATA_SIZE  result row; column j at bits [j*DATA_SIZE +: DATA_SIZE].
- busy  output  1  high in COLLECT and DRAIN.
- done  output  1  level; high from completion of a drain until the next accepted start.
- overflow_err  output  1  sticky; a result was dropped.

Behaviour:
- Reset values: out_valid=0, busy=0, done=0, overflow_err=0, out_data=0. State=IDLE. All column counters, the drain row index and the buffer are cleared.
- FSM states: IDLE, COLLECT, DRAIN. All state and outputs are registered, except out_data, which is a mux of buffer[drain_row].
- IDLE:
  - start=1 -> COLLECT next cycle. Clears all column counters and drops done.
  - col_valid bits seen in IDLE are dropped and set overflow_err.
- COLLECT:
  - Each column j has an index counter wr_idx[j], width $clog2(MATRIX_SIZE+1).
  - On col_valid[j] with wr_idx[j] < MATRIX_SIZE: write buffer[wr_idx[j]][j] <= col_data[j] and increment wr_idx[j].
  - On col_valid[j] with wr_idx[j] == MATRIX_SIZE: the element is dropped and overflow_err is set.
  - Columns are independent, and any skew between them is tolerated. Simultaneous valids on several columns are all written in the same cycle.
  - When every wr_idx equals MATRIX_SIZE (including writes landing this cycle), go to DRAIN. out_valid=1 the following cycle with drain_row=0.
  - start in COLLECT is ignored.
- DRAIN:
  - out_valid=1 and out_data=buffer[drain_row].
  - While out_valid && !out_ready, out_data and drain_row hold stable.
  - On handshake with drain_row < MATRIX_SIZE-1: drain_row increments.
  - On handshake with drain_row == MATRIX_SIZE-1: next cycle out_valid=0, done=1, state=IDLE.
  - col_valid in DRAIN is dropped and sets overflow_err. start is ignored.
- Rows are emitted in order 0..N-1; the buffer is read-only in DRAIN.
- busy = (state != IDLE).
- overflow_err clears only on reset or on an accepted start.
- Reset asserted mid-COLLECT or mid-DRAIN aborts immediately to the reset values; partial data is discarded.
- Minimum latency, last column write to first out_valid: 1 cycle.
- Minimum throughput: one row per cycle with out_ready held high.

Decomposition:
- Shared package systolic_pkg holds:
  - the collector state enum (IDLE, COLLECT, DRAIN);
  - a localparam function for counter width ($clog2(N+1)).
- One sub-module is natural: result_column_buffer, one instance per column. It holds the N-deep element storage, wr_idx, the full flag and the overflow detect, and exposes a read port indexed by drain_row.
- The top level holds the FSM, drain_row, and the busy/done/overflow_err registers.

Test Plan (MATRIX_SIZE=2, DATA_SIZE=32):
- Aligned columns:
  - Stimulus: start; then cycle 1 col_valid=2'b11, data {col1=0x11,col0=0x10}; cycle 2 col_valid=2'b11, data {0x21,0x20}; out_ready=1.
  - Response: out_valid on the next cycle. Rows are {0x11,0x10} then {0x21,0x20} on consecutive cycles, then done=1 and busy=0.
- Skewed columns:
  - Stimulus: col0 valid in cycles 1,2 (0xA0,0xB0); col1 valid in cycles 2,3 (0xA1,0xB1).
  - Response: first out_valid one cycle after cycle 3. Rows are {0xA1,0xA0}, {0xB1,0xB0}.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles during DRAIN, then 1.
  - Response: out_data holds row 0 unchanged for all 5 cycles, then row 0 and row 1 handshake in order. done rises after row 1.
- Overflow:
  - Stimulus: col0 receives a third valid (0xDEAD) after its 2 entries.
  - Response: overflow_err=1 and stays high. Output rows are unchanged, without 0xDEAD.
- Reset mid-operation:
  - Stimulus: assert reset while in DRAIN with drain_row=1.
  - Response: all outputs 0 at once. A new start collects fresh data correctly.
- Start ignored:
  - Stimulus: start pulse during COLLECT and again during DRAIN.
  - Response: no counter clear and no state change. Data integrity is preserved.
